// File: rtl/cvp14_sysmem_if.sv
// cvp14_sysmem_if
// Bundles the CVP14 processor bus, the program-load stream and the status
// outputs of the system memory. The slave modport is used by cvp14_sysmem;
// the master modport is the processor/loader side.
//   cpu_Addr/cpu_RD/cpu_WR/cpu_DataOut/cpu_V : processor -> memory
//   cpu_DataIn/cpu_Reset                     : memory -> processor
//   load_valid/load_data/load_last           : loader -> memory
//   load_ready/load_count/busy_load          : memory -> loader
//   v_sticky/oob_err/rdwr_err                : sticky status flags
interface cvp14_sysmem_if #(
  parameter int ADDR_W = 10
);
  logic [15:0]     cpu_Addr;
  logic            cpu_RD;
  logic            cpu_WR;
  logic [15:0]     cpu_DataOut;
  logic            cpu_V;
  logic [15:0]     cpu_DataIn;
  logic            cpu_Reset;
  logic            load_valid;
  logic [15:0]     load_data;
  logic            load_last;
  logic            load_ready;
  logic [ADDR_W:0] load_count;
  logic            busy_load;
  logic            v_sticky;
  logic            oob_err;
  logic            rdwr_err;

  modport slave (
    input  cpu_Addr, cpu_RD, cpu_WR, cpu_DataOut, cpu_V,
    input  load_valid, load_data, load_last,
    output cpu_DataIn, cpu_Reset, load_ready, load_count, busy_load,
    output v_sticky, oob_err, rdwr_err
  );

  modport master (
    output cpu_Addr, cpu_RD, cpu_WR, cpu_DataOut, cpu_V,
    output load_valid, load_data, load_last,
    input  cpu_DataIn, cpu_Reset, load_ready, load_count, busy_load,
    input  v_sticky, oob_err, rdwr_err
  );
endinterface

// File: rtl/cvp14_sysmem.sv
// cvp14_sysmem
// System memory and program loader for the CVP14 vector processor.
// After Reset the processor is held in reset while a program image streams
// in over the load port; RST_HOLD cycles after the last word the processor
// is released and this block serves as its word-addressed 16-bit RAM.
// Ports:
//   Clk1  : system clock, rising edge
//   Reset : synchronous, active-high
//   bus   : cvp14_sysmem_if.slave (processor bus, load port, status flags)
module cvp14_sysmem #(
  parameter int          ADDR_W    = 10,
  parameter logic [15:0] LOAD_BASE = 16'h0000,
  parameter int          RST_HOLD  = 2
) (
  input logic             Clk1,
  input logic             Reset,
  cvp14_sysmem_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LOAD_MAX = (ADDR_W + 1)'(DEPTH - int'(LOAD_BASE));

  typedef enum logic [1:0] {S_LOAD, S_HOLD, S_RUN} state_t;

  // Memory is never cleared, so a reset keeps the previous image.
  logic [15:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [15:0]     data_in_q, data_in_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic [ADDR_W:0] load_count_q, load_count_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  logic            v_sticky_q, v_sticky_d;
  logic            oob_err_q, oob_err_d;
  logic            rdwr_err_q, rdwr_err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;
  logic [16:0]       load_addr_ext;
  logic              cpu_oob;
  logic [ADDR_W-1:0] cpu_idx;

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_q      <= S_LOAD;
      data_in_q    <= 16'h0000;
      cpu_reset_q  <= 1'b1;
      load_count_q <= '0;
      hold_cnt_q   <= 8'd0;
      v_sticky_q   <= 1'b0;
      oob_err_q    <= 1'b0;
      rdwr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_in_q    <= data_in_d;
      cpu_reset_q  <= cpu_reset_d;
      load_count_q <= load_count_d;
      hold_cnt_q   <= hold_cnt_d;
      v_sticky_q   <= v_sticky_d;
      oob_err_q    <= oob_err_d;
      rdwr_err_q   <= rdwr_err_d;
    end
  end

  always_ff @(posedge Clk1) begin
    if (!Reset && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d       = state_q;
    data_in_d     = data_in_q;
    cpu_reset_d   = cpu_reset_q;
    load_count_d  = load_count_q;
    hold_cnt_d    = hold_cnt_q;
    v_sticky_d    = v_sticky_q;
    oob_err_d     = oob_err_q;
    rdwr_err_d    = rdwr_err_q;
    load_addr_ext = 17'(LOAD_BASE) + 17'(load_count_q);
    cpu_oob       = (bus.cpu_Addr >> ADDR_W) != 16'h0000;
    cpu_idx       = bus.cpu_Addr[ADDR_W-1:0];
    mem_we        = 1'b0;
    mem_waddr     = load_addr_ext[ADDR_W-1:0];
    mem_wdata     = bus.load_data;

    unique case (state_q)
      S_LOAD: begin
        cpu_reset_d = 1'b1;
        if (bus.load_valid && load_count_q != LOAD_MAX) begin
          mem_we       = 1'b1;
          load_count_d = load_count_q + 1'b1;
          // Landing on the top word ends the load even without load_last.
          if (bus.load_last || load_addr_ext == 17'(DEPTH - 1)) begin
            state_d    = S_HOLD;
            hold_cnt_d = 8'd0;
          end
        end
      end
      S_HOLD: begin
        if (hold_cnt_q == 8'(RST_HOLD - 1)) begin
          state_d     = S_RUN;
          cpu_reset_d = 1'b0;
          hold_cnt_d  = 8'd0;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        cpu_reset_d = 1'b0;
        if (bus.cpu_V) begin
          v_sticky_d = 1'b1;
        end
        if (bus.cpu_RD) begin
          data_in_d = cpu_oob ? 16'h0000 : mem[cpu_idx];
        end
        // A simultaneous read wins; the write is dropped.
        if (bus.cpu_WR && !bus.cpu_RD && !cpu_oob) begin
          mem_we    = 1'b1;
          mem_waddr = cpu_idx;
          mem_wdata = bus.cpu_DataOut;
        end
        if ((bus.cpu_RD || bus.cpu_WR) && cpu_oob) begin
          oob_err_d = 1'b1;
        end
        if (bus.cpu_RD && bus.cpu_WR) begin
          rdwr_err_d = 1'b1;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  assign bus.cpu_DataIn = data_in_q;
  assign bus.cpu_Reset  = cpu_reset_q;
  assign bus.load_ready = (state_q == S_LOAD);
  assign bus.busy_load  = (state_q == S_LOAD) || (state_q == S_HOLD);
  assign bus.load_count = load_count_q;
  assign bus.v_sticky   = v_sticky_q;
  assign bus.oob_err    = oob_err_q;
  assign bus.rdwr_err   = rdwr_err_q;
endmodule

// File: tb/tb_cvp14_sysmem.sv
// tb_cvp14_sysmem
// Self-checking bench for cvp14_sysmem. Reads issued on the processor bus
// push their expected data (from a bench-side memory model) onto a queue;
// the value is popped and compared one edge later when cpu_DataIn updates.
module tb_cvp14_sysmem;
  logic Clk1;
  logic Reset;

  cvp14_sysmem_if #(.ADDR_W(10)) bus ();

  cvp14_sysmem #(
    .ADDR_W(10),
    .LOAD_BASE(16'h0000),
    .RST_HOLD(2)
  ) dut (
    .Clk1(Clk1),
    .Reset(Reset),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [15:0] exp_q [$];
  logic [15:0] ref_mem [0:1023];

  initial Clk1 = 1'b0;
  always #5 Clk1 = ~Clk1;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge Clk1);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_Addr    = 16'h0000;
    bus.cpu_RD      = 1'b0;
    bus.cpu_WR      = 1'b0;
    bus.cpu_DataOut = 16'h0000;
    bus.cpu_V       = 1'b0;
    bus.load_valid  = 1'b0;
    bus.load_data   = 16'h0000;
    bus.load_last   = 1'b0;
  endtask

  // One processor bus cycle in RUN; the read result is checked via the queue.
  task automatic cpu_op(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] dout, input string name);
    logic [15:0] got_exp;
    bus.cpu_RD      = rd;
    bus.cpu_WR      = wr;
    bus.cpu_Addr    = addr;
    bus.cpu_DataOut = dout;
    if (rd) exp_q.push_back(addr >= 16'd1024 ? 16'h0000 : ref_mem[addr[9:0]]);
    tick();
    if (wr && !rd && addr < 16'd1024) ref_mem[addr[9:0]] = dout;
    if (rd) begin
      got_exp = exp_q.pop_front();
      n_cmp++;
      if (bus.cpu_DataIn !== got_exp) begin
        n_fail++;
        $display("[TB] FAIL %s: cpu_DataIn=%h expected %h (addr %h)", name, bus.cpu_DataIn, got_exp, addr);
      end
    end
  endtask

  task automatic wait_run(input string name);
    int cycles = 0;
    while (bus.cpu_Reset !== 1'b0 && cycles < 8) begin
      tick();
      cycles++;
    end
    n_cmp++;
    if (bus.cpu_Reset !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s: cpu_Reset=%b expected 0 within 8 cycles", name, bus.cpu_Reset);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    Reset = 1'b0;
    n_cmp++;
    if ({bus.cpu_Reset, bus.load_ready, bus.busy_load} !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: {cpu_Reset,ready,busy}=%b expected 111", {bus.cpu_Reset, bus.load_ready, bus.busy_load});
    end
    n_cmp++;
    if (bus.load_count !== 11'd0 || bus.cpu_DataIn !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL reset_regs: load_count=%0d cpu_DataIn=%h expected 0/0000", bus.load_count, bus.cpu_DataIn);
    end
    n_cmp++;
    if ({bus.v_sticky, bus.oob_err, bus.rdwr_err} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: {v,oob,rdwr}=%b expected 000", {bus.v_sticky, bus.oob_err, bus.rdwr_err});
    end
  endtask

  task automatic test_load();
    logic [15:0] img [4];
    img = '{16'hF000, 16'h8002, 16'h1234, 16'hABCD};
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = img[i];
      bus.load_last  = (i == 3);
      tick();
      ref_mem[i] = img[i];
      n_cmp++;
      if (bus.load_count !== 11'(i + 1)) begin
        n_fail++;
        $display("[TB] FAIL load_count_%0d: load_count=%0d expected %0d", i, bus.load_count, i + 1);
      end
    end
    idle_inputs();
    n_cmp++;
    if ({bus.cpu_Reset, bus.busy_load, bus.load_ready} !== 3'b110) begin
      n_fail++;
      $display("[TB] FAIL hold_entry: {cpu_Reset,busy,ready}=%b expected 110", {bus.cpu_Reset, bus.busy_load, bus.load_ready});
    end
    tick();
    n_cmp++;
    if ({bus.cpu_Reset, bus.busy_load} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL hold_cycle1: {cpu_Reset,busy}=%b expected 11", {bus.cpu_Reset, bus.busy_load});
    end
    tick();
    n_cmp++;
    if ({bus.cpu_Reset, bus.busy_load} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL hold_release: {cpu_Reset,busy}=%b expected 00", {bus.cpu_Reset, bus.busy_load});
    end
    // Back-to-back reads of the loaded image.
    for (int i = 0; i < 4; i++) cpu_op(1'b1, 1'b0, 16'(i), 16'h0000, "image_readback");
    idle_inputs();
  endtask

  task automatic test_run_rw();
    cpu_op(1'b0, 1'b1, 16'h0010, 16'h5A5A, "write_0x10");
    cpu_op(1'b1, 1'b0, 16'h0010, 16'h0000, "raw_0x10");
    cpu_op(1'b0, 1'b0, 16'h0002, 16'h0000, "rd_low");
    n_cmp++;
    if (bus.cpu_DataIn !== 16'h5A5A) begin
      n_fail++;
      $display("[TB] FAIL datain_hold: cpu_DataIn=%h expected 5a5a", bus.cpu_DataIn);
    end
    n_cmp++;
    if (bus.load_count !== 11'd4) begin
      n_fail++;
      $display("[TB] FAIL count_frozen: load_count=%0d expected 4", bus.load_count);
    end
  endtask

  task automatic test_oob();
    n_cmp++;
    if (bus.oob_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL oob_pre: oob_err=%b expected 0", bus.oob_err);
    end
    cpu_op(1'b1, 1'b0, 16'h0400, 16'h0000, "oob_read");
    n_cmp++;
    if (bus.oob_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL oob_flag: oob_err=%b expected 1", bus.oob_err);
    end
    cpu_op(1'b0, 1'b1, 16'h0400, 16'hDEAD, "oob_write");
    cpu_op(1'b1, 1'b0, 16'h0000, 16'h0000, "oob_write_dropped");
    cpu_op(1'b0, 1'b0, 16'h0000, 16'h0000, "idle");
    n_cmp++;
    if (bus.oob_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL oob_sticky: oob_err=%b expected 1", bus.oob_err);
    end
  endtask

  task automatic test_collision();
    n_cmp++;
    if (bus.rdwr_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rdwr_pre: rdwr_err=%b expected 0", bus.rdwr_err);
    end
    cpu_op(1'b1, 1'b1, 16'h0003, 16'hFFFF, "collision_read");
    n_cmp++;
    if (bus.rdwr_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rdwr_flag: rdwr_err=%b expected 1", bus.rdwr_err);
    end
    cpu_op(1'b1, 1'b0, 16'h0003, 16'h0000, "collision_write_dropped");
    n_cmp++;
    if (bus.v_sticky !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL v_pre: v_sticky=%b expected 0", bus.v_sticky);
    end
    bus.cpu_V = 1'b1;
    cpu_op(1'b0, 1'b0, 16'h0000, 16'h0000, "v_pulse");
    bus.cpu_V = 1'b0;
    for (int i = 0; i < 3; i++) cpu_op(1'b0, 1'b0, 16'h0000, 16'h0000, "v_idle");
    n_cmp++;
    if (bus.v_sticky !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL v_sticky: v_sticky=%b expected 1", bus.v_sticky);
    end
  endtask

  task automatic test_reset_mid_run();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_cmp++;
    if ({bus.cpu_Reset, bus.load_ready, bus.v_sticky, bus.oob_err, bus.rdwr_err} !== 5'b11000) begin
      n_fail++;
      $display("[TB] FAIL midrun_reset: {cpu_Reset,ready,v,oob,rdwr}=%b expected 11000",
               {bus.cpu_Reset, bus.load_ready, bus.v_sticky, bus.oob_err, bus.rdwr_err});
    end
    n_cmp++;
    if (bus.load_count !== 11'd0 || bus.cpu_DataIn !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL midrun_regs: load_count=%0d cpu_DataIn=%h expected 0/0000", bus.load_count, bus.cpu_DataIn);
    end
  endtask

  task automatic test_load_gaps();
    logic       vld [4];
    logic [15:0] dat [4];
    int          cnt [4];
    vld = '{1'b1, 1'b0, 1'b0, 1'b1};
    dat = '{16'h1111, 16'h9999, 16'h7777, 16'h2222};
    cnt = '{1, 1, 1, 2};
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = vld[i];
      bus.load_data  = dat[i];
      bus.load_last  = (i != 0);
      tick();
      n_cmp++;
      if (bus.load_count !== 11'(cnt[i])) begin
        n_fail++;
        $display("[TB] FAIL gap_count_%0d: load_count=%0d expected %0d", i, bus.load_count, cnt[i]);
      end
    end
    ref_mem[0] = 16'h1111;
    ref_mem[1] = 16'h2222;
    idle_inputs();
    wait_run("gap_release");
    for (int i = 0; i < 3; i++) cpu_op(1'b1, 1'b0, 16'(i), 16'h0000, "gap_readback");
    cpu_op(1'b1, 1'b0, 16'h0010, 16'h0000, "mem_kept_0x10");
    idle_inputs();
  endtask

  task automatic test_full_load();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 16'(i) ^ 16'hC3C3;
      bus.load_last  = 1'b0;
      tick();
      ref_mem[i] = 16'(i) ^ 16'hC3C3;
      if (i == 1022) begin
        n_cmp++;
        if ({bus.load_ready, bus.busy_load} !== 2'b11) begin
          n_fail++;
          $display("[TB] FAIL full_penultimate: {ready,busy}=%b expected 11", {bus.load_ready, bus.busy_load});
        end
      end
    end
    n_cmp++;
    if (bus.load_count !== 11'd1024 || {bus.load_ready, bus.busy_load} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL full_hold: load_count=%0d {ready,busy}=%b expected 1024/01",
               bus.load_count, {bus.load_ready, bus.busy_load});
    end
    bus.load_data = 16'hDEAD;
    tick();
    n_cmp++;
    if (bus.load_count !== 11'd1024) begin
      n_fail++;
      $display("[TB] FAIL full_saturate: load_count=%0d expected 1024", bus.load_count);
    end
    idle_inputs();
    wait_run("full_release");
    cpu_op(1'b1, 1'b0, 16'h0000, 16'h0000, "full_word0");
    cpu_op(1'b1, 1'b0, 16'h03FF, 16'h0000, "full_word1023");
    cpu_op(1'b1, 1'b0, 16'h0010, 16'h0000, "full_word16");
    idle_inputs();
  endtask

  initial begin
    Reset = 1'b1;
    idle_inputs();
    test_reset();
    test_load();
    test_run_rw();
    test_oob();
    test_collision();
    test_reset_mid_run();
    test_load_gaps();
    test_full_load();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cvp14_sysmem.md
Name: cvp14_sysmem

Overview:
- System memory and program loader for the CVP14 vector processor; services the processor's Addr/RD/WR/DataOut bus and drives its DataIn.
- After Reset, holds the processor in reset while a program image streams in over a valid/ready load port. It then releases the processor and acts as its word-addressed 16-bit RAM.
- Also captures sticky status: overflow flag V, out-of-range access, and RD/WR collision.

Parameters:
ADDR_W, 10, implemented address bits; DEPTH = 2**ADDR_W words
LOAD_BASE, 16'h0000, first address written by the loader (processor starts fetching at PC 0)
RST_HOLD, 2, Clk1 cycles cpu_Reset stays high after the load completes

Ports:
Clk1  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high
cpu_Addr  in  16  word address from processor
cpu_RD  in  1  read strobe
cpu_WR  in  1  write strobe
cpu_DataOut  in  16  write data from processor
cpu_V  in  1  processor overflow flag
cpu_DataIn  out  16  read data to processor (registered)
cpu_Reset  out  1  reset to processor
load_valid  in  1  load word valid
load_data  in  16  load word
load_last  in  1  final word of image, qualified by load_valid
load_ready  out  1  loader accepts a word this cycle
load_count  out  ADDR_W+1  words accepted in current load
busy_load  out  1  high while in LOAD or HOLD
v_sticky  out  1  cpu_V seen high during RUN
oob_err  out  1  sticky: access with cpu_Addr >= DEPTH
rdwr_err  out  1  sticky: cpu_RD and cpu_WR high together

Behaviour:
- All state updates on rising Clk1. Reset has priority over everything.
- Reset values: state=LOAD, cpu_DataIn=0, cpu_Reset=1, load_count=0, v_sticky=0, oob_err=0, rdwr_err=0, hold counter=0.
- Memory contents are not cleared by Reset. Reset mid-RUN or mid-LOAD returns to LOAD, restarts the pointer at LOAD_BASE, and keeps existing memory words.
- load_ready = (state==LOAD). busy_load = (state==LOAD or HOLD). Both are combinational from state.

FSM states:
- LOAD:
  - A handshake (load_valid & load_ready) writes load_data to mem[LOAD_BASE+load_count] and increments load_count.
  - Go to HOLD if load_last is high on the accepting cycle.
  - Also go to HOLD if the accepted word lands at address DEPTH-1 (memory full); later words are never written.
  - load_valid low: no action.
  - cpu_* inputs are ignored in LOAD and HOLD.
- HOLD:
  - cpu_Reset stays 1; the hold counter counts RST_HOLD cycles.
  - Go to RUN on the cycle the counter reaches RST_HOLD-1. cpu_Reset is registered low on that same edge.
- RUN:
  - cpu_Reset=0; load_valid is ignored and load_count is frozen.
  - Read: cpu_RD sampled high → cpu_DataIn <= mem[cpu_Addr[ADDR_W-1:0]] at that edge. Latency is one Clk1 edge; the processor samples on the following Clk2.
  - cpu_DataIn holds its value when cpu_RD is low.
  - Consecutive cycles with cpu_RD high (vector load bursts) update cpu_DataIn every edge.
  - Write: cpu_WR high and cpu_RD low → mem[cpu_Addr] <= cpu_DataOut.
  - cpu_RD and cpu_WR both high: the read is performed, the write is suppressed, and rdwr_err is set.
  - Out of range (cpu_Addr >= DEPTH, i.e. any bit above ADDR_W-1 set) with RD or WR high:
    - reads return 16'h0000;
    - writes are dropped;
    - oob_err is set.
  - v_sticky is set on any RUN edge with cpu_V=1.
- All sticky flags clear only on Reset.
- load_count saturates at DEPTH-LOAD_BASE; there is no wrap.
- Read-after-write to the same address on consecutive edges returns the new data. Same-edge read+write cannot occur because the write is suppressed.

Test Plan:
- Reset, stream 4 words 16'hF000,16'h8002,16'h1234,16'hABCD with load_last on the 4th → load_count=4, mem[0..3] match, cpu_Reset falls exactly RST_HOLD=2 cycles after the last handshake, busy_load falls together with it.
- Load with load_valid gaps (valid 1,0,0,1 with last) → only 2 words written, no count increment on idle cycles.
- RUN: write 16'h5A5A to addr 16'h0010, then read addr 16'h0010 on the next edge → cpu_DataIn=16'h5A5A one edge after cpu_RD sampled; cpu_DataIn is unchanged when cpu_RD drops.
- RUN: read addr 16'h0400 (DEPTH=1024) → cpu_DataIn=0, oob_err=1. Write there → mem[0] unchanged.
- RUN: cpu_RD=cpu_WR=1 at addr 3 with DataOut 16'hFFFF → mem[3] unchanged, cpu_DataIn=old mem[3], rdwr_err=1. Pulse cpu_V once → v_sticky=1 and holds.
- Assert Reset mid-RUN → cpu_Reset=1 next edge, state LOAD, flags cleared, mem[0x10] still 16'h5A5A. Full-memory load of DEPTH words without load_last → HOLD entered after word DEPTH-1, load_count=1024.
